// File: rtl/shc_seq.sv
// rtl/shc_seq.sv - multi-cycle LSHC/ROTC/ASHC combined-shift sequencer for AR!ARX
//
// Bit numbering: the machine numbers words [0:35] with bit 0 as the MSB.
// Here vectors are declared [35:0], so AR_in[35] is machine bit AR[0] (the
// sign) and ARX_in[0] is machine bit ARX[35]. The 72-bit working register
// wrk_q holds AR in [71:36] and ARX in [35:0]; wrk_q[71] is AR[0] and
// wrk_q[35] is ARX[0].

module shc_seq #(
    parameter int STEP_MAX = 36
) (
    input  logic        eboxClk,
    input  logic        eboxRstN,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [8:0]  count,
    input  logic [35:0] AR_in,
    input  logic [35:0] ARX_in,
    output logic        busy,
    output logic        done,
    output logic [35:0] AR_out,
    output logic [35:0] ARX_out,
    output logic        overflow
);

    localparam logic [6:0] STEP_W = 7'(STEP_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_LSH = 2'd0,
        OP_ROT = 2'd1,
        OP_ASH = 2'd2
    } op_e;

    state_e      state_q;
    op_e         op_q;
    logic        dir_q;        // 1 = right shift (negative count)
    logic [6:0]  rem_q;        // bit positions still to shift, 0..72
    logic [71:0] wrk_q;        // AR!ARX working value, also the outputs
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;

    // Acceptance-side decode
    logic [8:0]  cnt_abs;
    op_e         op_d;
    logic [6:0]  eff_d;
    logic [71:0] load_w;

    // Per-cycle shift datapath
    logic [6:0]   step_s;
    logic         sign_b;
    logic [69:0]  mag;
    logic [141:0] ash_l_ext;
    logic [70:0]  ash_r;
    logic [71:0]  ash_lost;
    logic [71:0]  step_mask;
    logic [71:0]  rot_l;
    logic [71:0]  rot_r;
    logic [71:0]  step_w;
    logic         step_ovf;

    // Decode an incoming request: magnitude, operation and clamped effective count
    always_comb begin
        cnt_abs = count[8] ? (~count + 9'd1) : count;

        case (mode)
            2'b01:   op_d = OP_ROT;
            2'b10:   op_d = OP_ASH;
            default: op_d = OP_LSH;   // 11 is reserved and behaves as LSHC
        endcase

        case (op_d)
            OP_ROT:  eff_d = 7'(cnt_abs % 9'd72);
            OP_ASH:  eff_d = (cnt_abs > 9'd71) ? 7'd71 : cnt_abs[6:0];
            default: eff_d = (cnt_abs > 9'd72) ? 7'd72 : cnt_abs[6:0];
        endcase

        // ASHC forces ARX[0] to the sign up front so a zero-count ASHC
        // still completes with ARX[0] = sign.
        load_w = {AR_in, ARX_in};
        if (op_d == OP_ASH) begin
            load_w[35] = AR_in[35];
        end
    end

    // One chunk of shifting: up to STEP_MAX positions of the selected operation
    always_comb begin
        step_s = (rem_q > STEP_W) ? STEP_W : rem_q;

        // ASHC sees a sign bit plus a 70-bit magnitude AR[1:35]!ARX[1:35]
        sign_b = wrk_q[71];
        mag    = {wrk_q[70:36], wrk_q[34:0]};

        // Left: the upper 72 bits collect whatever leaves past AR[1]
        ash_l_ext = {72'd0, mag} << step_s;
        ash_lost  = ash_l_ext[141:70];
        step_mask = ~({72{1'b1}} << step_s);

        // Right: arithmetic shift replicates the sign into AR[1]
        ash_r = 71'($signed({sign_b, mag}) >>> step_s);

        rot_l = (wrk_q << step_s) | (wrk_q >> (7'd72 - step_s));
        rot_r = (wrk_q >> step_s) | (wrk_q << (7'd72 - step_s));

        case (op_q)
            OP_ROT:  step_w = dir_q ? rot_r : rot_l;
            OP_ASH:  step_w = dir_q ? {ash_r[70], ash_r[69:35], ash_r[70], ash_r[34:0]}
                                    : {sign_b, ash_l_ext[69:35], sign_b, ash_l_ext[34:0]};
            default: step_w = dir_q ? (wrk_q >> step_s) : (wrk_q << step_s);
        endcase

        // Any lost bit that disagrees with the sign means significance was lost
        step_ovf = (op_q == OP_ASH) && !dir_q &&
                   (|((ash_lost ^ {72{sign_b}}) & step_mask));
    end

    // Sequencer FSM with registered busy/done/overflow and working value
    always_ff @(posedge eboxClk or negedge eboxRstN) begin
        if (!eboxRstN) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LSH;
            dir_q   <= 1'b0;
            rem_q   <= 7'd0;
            wrk_q   <= 72'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        op_q  <= op_d;
                        dir_q <= count[8];
                        rem_q <= eff_d;
                        wrk_q <= load_w;
                        ovf_q <= 1'b0;
                        if (eff_d == 7'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    wrk_q <= step_w;
                    ovf_q <= ovf_q | step_ovf;
                    rem_q <= rem_q - step_s;
                    if (rem_q == step_s) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign AR_out   = wrk_q[71:36];
    assign ARX_out  = wrk_q[35:0];

endmodule

// File: tb/tb_shc_seq.sv
// tb/tb_shc_seq.sv - self-checking bench for shc_seq (STEP_MAX 36 and 1 side by side)

module tb_shc_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [8:0]  count;
    logic [35:0] ar_in;
    logic [35:0] arx_in;

    logic        busy_a, done_a, ovf_a;
    logic [35:0] ar_a, arx_a;
    logic        busy_b, done_b, ovf_b;
    logic [35:0] ar_b, arx_b;

    int n_pass;
    int n_total;

    shc_seq #(.STEP_MAX(36)) dut_a (
        .eboxClk (clk),
        .eboxRstN(rst_n),
        .start   (start),
        .mode    (mode),
        .count   (count),
        .AR_in   (ar_in),
        .ARX_in  (arx_in),
        .busy    (busy_a),
        .done    (done_a),
        .AR_out  (ar_a),
        .ARX_out (arx_a),
        .overflow(ovf_a)
    );

    shc_seq #(.STEP_MAX(1)) dut_b (
        .eboxClk (clk),
        .eboxRstN(rst_n),
        .start   (start),
        .mode    (mode),
        .count   (count),
        .AR_in   (ar_in),
        .ARX_in  (arx_in),
        .busy    (busy_b),
        .done    (done_b),
        .AR_out  (ar_b),
        .ARX_out (arx_b),
        .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    // Reference: apply the operation one bit position at a time
    function automatic void model(input logic [1:0] m, input logic [8:0] c,
                                  input logic [35:0] a, input logic [35:0] x,
                                  output logic [35:0] ra, output logic [35:0] rx,
                                  output logic ov, output int eff);
        int          n;
        bit          right;
        logic [71:0] w;
        logic [69:0] mg;
        logic        sg;
        right = c[8];
        n     = right ? (512 - int'(c)) : int'(c);
        case (m)
            2'b01:   eff = n % 72;
            2'b10:   eff = (n > 71) ? 71 : n;
            default: eff = (n > 72) ? 72 : n;
        endcase
        w  = {a, x};
        ov = 1'b0;
        if (m == 2'b10) begin
            sg = w[71];
            mg = {w[70:36], w[34:0]};
            for (int i = 0; i < eff; i++) begin
                if (right) begin
                    mg = {sg, mg[69:1]};
                end else begin
                    if (mg[69] != sg) ov = 1'b1;
                    mg = {mg[68:0], 1'b0};
                end
            end
            w = {sg, mg[69:35], sg, mg[34:0]};
        end else begin
            for (int i = 0; i < eff; i++) begin
                if (m == 2'b01) w = right ? {w[0], w[71:1]} : {w[70:0], w[71]};
                else            w = right ? {1'b0, w[71:1]} : {w[70:0], 1'b0};
            end
        end
        ra = w[71:36];
        rx = w[35:0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one request with both instances idle and watch both until done
    task automatic run_op(input logic [1:0] m, input logic [8:0] c,
                          input logic [35:0] a, input logic [35:0] x,
                          output int lat_a, output logic [72:0] res_a,
                          output int lat_b, output logic [72:0] res_b,
                          output int busy_err);
        @(negedge clk);
        mode = m; count = c; ar_in = a; arx_in = x; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        lat_a    = -1;
        lat_b    = -1;
        res_a    = 'x;
        res_b    = 'x;
        busy_err = 0;
        for (int cyc = 1; cyc <= 200 && (lat_a < 0 || lat_b < 0); cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (lat_a < 0) begin
                if (done_a) begin
                    lat_a = cyc; res_a = {ar_a, arx_a, ovf_a};
                    if (busy_a) busy_err++;
                end else if (!busy_a) busy_err++;
            end
            if (lat_b < 0) begin
                if (done_b) begin
                    lat_b = cyc; res_b = {ar_b, arx_b, ovf_b};
                    if (busy_b) busy_err++;
                end else if (!busy_b) busy_err++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode = 2'b00; count = 9'd0; ar_in = '0; arx_in = '0;
        @(negedge clk);
        n_total++;
        if ({busy_a, done_a, ovf_a, ar_a, arx_a} !== 75'd0) begin
            $display("FAIL reset_a: got %h required 0", {busy_a, done_a, ovf_a, ar_a, arx_a});
        end else n_pass++;
        n_total++;
        if ({busy_b, done_b, ovf_b, ar_b, arx_b} !== 75'd0) begin
            $display("FAIL reset_b: got %h required 0", {busy_b, done_b, ovf_b, ar_b, arx_b});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [8:0]  c;
        logic [35:0] a, x, ea, ex;
        logic        eo;
        int          la, lb;
    } dir_t;

    task automatic test_directed();
        dir_t        tbl [7];
        int          la, lb, be;
        logic [72:0] ra, rb;
        tbl[0] = '{2'b00, 9'd36,  36'o0, 36'o1, 36'o1, 36'o0, 1'b0, 2, 37};
        tbl[1] = '{2'b01, 9'h1FF, 36'o0, 36'o1, 36'o400000000000, 36'o0, 1'b0, 2, 2};
        tbl[2] = '{2'b01, 9'd72,  36'o0, 36'o1, 36'o0, 36'o1, 1'b0, 1, 1};
        tbl[3] = '{2'b00, 9'd100, 36'o777777777777, 36'o777777777777, 36'o0, 36'o0, 1'b0, 3, 73};
        tbl[4] = '{2'b10, 9'd1,   36'o200000000000, 36'o0, 36'o0, 36'o0, 1'b1, 2, 2};
        tbl[5] = '{2'b10, 9'h1FE, 36'o400000000000, 36'o0, 36'o700000000000, 36'o400000000000, 1'b0, 2, 3};
        tbl[6] = '{2'b11, 9'h100, 36'o123, 36'o456, 36'o0, 36'o0, 1'b0, 3, 73};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].m, tbl[i].c, tbl[i].a, tbl[i].x, la, ra, lb, rb, be);
            n_total++;
            if (ra !== {tbl[i].ea, tbl[i].ex, tbl[i].eo}) begin
                $display("FAIL dir%0d_res_a: got %h required %h", i, ra, {tbl[i].ea, tbl[i].ex, tbl[i].eo});
            end else n_pass++;
            n_total++;
            if (rb !== {tbl[i].ea, tbl[i].ex, tbl[i].eo}) begin
                $display("FAIL dir%0d_res_b: got %h required %h", i, rb, {tbl[i].ea, tbl[i].ex, tbl[i].eo});
            end else n_pass++;
            n_total++;
            if (la != tbl[i].la) begin
                $display("FAIL dir%0d_lat_a: got %0d required %0d", i, la, tbl[i].la);
            end else n_pass++;
            n_total++;
            if (lb != tbl[i].lb) begin
                $display("FAIL dir%0d_lat_b: got %0d required %0d", i, lb, tbl[i].lb);
            end else n_pass++;
            n_total++;
            if (be != 0) begin
                $display("FAIL dir%0d_busy: got %0d bad cycles required 0", i, be);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [8:0]  bnd [14];
        logic [1:0]  m;
        logic [8:0]  c;
        logic [35:0] a, x, ea, ex;
        logic        eo;
        int          eff, la, lb, be;
        logic [72:0] ra, rb;
        bnd = '{9'd0, 9'd1, 9'd35, 9'd36, 9'd37, 9'd71, 9'd72, 9'd73,
                9'h1FF, 9'h1B9, 9'h1B8, 9'h100, 9'h0FF, 9'd144};
        do_reset();
        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 13)] : 9'($urandom());
            a = rnd36();
            x = rnd36();
            if ($urandom_range(0, 3) == 0) begin
                a = a[35] ? 36'o777777777777 : 36'o0;
                x = {x[35], 27'd0, x[7:0]};
            end
            model(m, c, a, x, ea, ex, eo, eff);
            run_op(m, c, a, x, la, ra, lb, rb, be);
            n_total++;
            if (ra !== {ea, ex, eo}) begin
                $display("FAIL rnd%0d_res_a m=%0d c=%h: got %h required %h", i, m, c, ra, {ea, ex, eo});
            end else n_pass++;
            n_total++;
            if (rb !== {ea, ex, eo}) begin
                $display("FAIL rnd%0d_res_b m=%0d c=%h: got %h required %h", i, m, c, rb, {ea, ex, eo});
            end else n_pass++;
            n_total++;
            if (la != 1 + (eff + 35) / 36) begin
                $display("FAIL rnd%0d_lat_a: got %0d required %0d", i, la, 1 + (eff + 35) / 36);
            end else n_pass++;
            n_total++;
            if (lb != 1 + eff) begin
                $display("FAIL rnd%0d_lat_b: got %0d required %0d", i, lb, 1 + eff);
            end else n_pass++;
            n_total++;
            if (be != 0) begin
                $display("FAIL rnd%0d_busy: got %0d bad cycles required 0", i, be);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] a1, x1, a2, x2, ea, ex;
        logic        eo;
        int          eff;
        do_reset();
        a1 = rnd36(); x1 = rnd36(); a2 = rnd36(); x2 = rnd36();
        @(negedge clk);
        mode = 2'b00; count = 9'd40; ar_in = a1; arx_in = x1; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            n_total++;
            if ({busy_a, done_a} !== 2'b10) begin
                $display("FAIL b2b_cyc%0d_busy_done: got %b required 10", cyc, {busy_a, done_a});
            end else n_pass++;
            count = 9'd0; ar_in = ~a1; arx_in = ~x1;
        end
        @(negedge clk);
        n_total++;
        if ({busy_a, done_a} !== 2'b01) begin
            $display("FAIL b2b_cyc3_busy_done: got %b required 01", {busy_a, done_a});
        end else n_pass++;
        model(2'b00, 9'd40, a1, x1, ea, ex, eo, eff);
        n_total++;
        if ({ar_a, arx_a, ovf_a} !== {ea, ex, eo}) begin
            $display("FAIL b2b_res1: got %h required %h", {ar_a, arx_a, ovf_a}, {ea, ex, eo});
        end else n_pass++;
        count = 9'd40; ar_in = a2; arx_in = x2;
        for (int cyc = 4; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            n_total++;
            if ({busy_a, done_a} !== 2'b10) begin
                $display("FAIL b2b_cyc%0d_busy_done: got %b required 10", cyc, {busy_a, done_a});
            end else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({busy_a, done_a} !== 2'b01) begin
            $display("FAIL b2b_cyc6_busy_done: got %b required 01", {busy_a, done_a});
        end else n_pass++;
        model(2'b00, 9'd40, a2, x2, ea, ex, eo, eff);
        n_total++;
        if ({ar_a, arx_a, ovf_a} !== {ea, ex, eo}) begin
            $display("FAIL b2b_res2: got %h required %h", {ar_a, arx_a, ovf_a}, {ea, ex, eo});
        end else n_pass++;
        // zero count: done on cycle 1, busy never seen
        @(negedge clk);
        mode = 2'b00; count = 9'd0; ar_in = a1; arx_in = x1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if ({busy_a, done_a, ar_a, arx_a, ovf_a} !== {2'b01, a1, x1, 1'b0}) begin
            $display("FAIL zero_cnt: got %h required %h", {busy_a, done_a, ar_a, arx_a, ovf_a}, {2'b01, a1, x1, 1'b0});
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy_a, done_a} !== 2'b00) begin
            $display("FAIL zero_cnt_after: got %b required 00", {busy_a, done_a});
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [35:0] a, x, ea, ex;
        logic        eo;
        int          eff, la, lb, be, spurious;
        logic [72:0] ra, rb;
        do_reset();
        a = rnd36() | 36'd1; x = rnd36() | 36'd1;
        @(negedge clk);
        mode = 2'b01; count = 9'd71; ar_in = a; arx_in = x; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (busy_a !== 1'b1) begin
            $display("FAIL rmid_busy_before: got %b required 1", busy_a);
        end else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy_a, done_a, ovf_a, ar_a, arx_a} !== 75'd0) begin
            $display("FAIL rmid_async_a: got %h required 0", {busy_a, done_a, ovf_a, ar_a, arx_a});
        end else n_pass++;
        n_total++;
        if ({busy_b, done_b, ovf_b, ar_b, arx_b} !== 75'd0) begin
            $display("FAIL rmid_async_b: got %h required 0", {busy_b, done_b, ovf_b, ar_b, arx_b});
        end else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (done_a || done_b || busy_a || busy_b) spurious++;
        end
        n_total++;
        if (spurious != 0) begin
            $display("FAIL rmid_no_done: got %0d active cycles required 0", spurious);
        end else n_pass++;
        model(2'b01, 9'd71, a, x, ea, ex, eo, eff);
        run_op(2'b01, 9'd71, a, x, la, ra, lb, rb, be);
        n_total++;
        if (ra !== {ea, ex, eo} || la != 3) begin
            $display("FAIL rmid_after_a: got %h lat %0d required %h lat 3", ra, la, {ea, ex, eo});
        end else n_pass++;
        n_total++;
        if (rb !== {ea, ex, eo} || lb != 72) begin
            $display("FAIL rmid_after_b: got %h lat %0d required %h lat 72", rb, lb, {ea, ex, eo});
        end else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
